i2c_fifo_slave: RTL and testbench

I2C target that sits directly downstream of the I2C master inside `I2C_Wrapper` and consumes the SCL/SDA waveforms that master produces. The block decodes START/STOP, matches its 7-bit address, pushes written bytes into an internal FIFO, and returns FIFO contents on reads. All logic runs in the system clock domain and oversamples the bus. SDA is driven open-drain style: the block only ever pulls the line low.

---
 rtl/i2c_fifo_slave.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_i2c_fifo_slave.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_fifo_slave.sv
// I2C target that buffers written bytes in a FIFO and returns them on reads.
// Build option: I2C_FIFO_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
//
// state     | meaning
// IDLE      | bus free, ignore traffic
// ADDR      | shifting in the address byte
// ADDR_ACK  | driving the address ACK slot
// WR_DATA   | shifting in a write byte
// WR_ACK    | ACK/NACK slot for a write byte
// RD_DATA   | shifting out a read byte
// RD_MACK   | sampling the master ACK after a read byte
// WAIT_STOP | not addressed, wait for STOP or START
module i2c_fifo_slave #(
  parameter int         DEPTH      = 8,
  parameter logic [6:0] SLAVE_ADDR = 7'h19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     scl,
  input  logic                     sda_in,
  output logic                     sda_oe,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     overflow,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_MACK, WAIT_STOP
  } state_t;

  logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
  logic scl_prev_q, sda_prev_q;
  logic scl_v, sda_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
    end else begin
      scl_s1_q <= scl;
      scl_s2_q <= scl_s1_q;
      sda_s1_q <= sda_in;
      sda_s2_q <= sda_s1_q;
    end
  end

`ifdef I2C_FIFO_SLAVE_GLITCH_FILTER_EN
  logic scl_h1_q, scl_h2_q, scl_f_q, sda_h1_q, sda_h2_q, sda_f_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_h1_q <= 1'b1;
      scl_h2_q <= 1'b1;
      scl_f_q  <= 1'b1;
      sda_h1_q <= 1'b1;
      sda_h2_q <= 1'b1;
      sda_f_q  <= 1'b1;
    end else begin
      scl_h1_q <= scl_s2_q;
      scl_h2_q <= scl_h1_q;
      scl_f_q  <= (scl_s2_q & scl_h1_q) | (scl_s2_q & scl_h2_q) | (scl_h1_q & scl_h2_q);
      sda_h1_q <= sda_s2_q;
      sda_h2_q <= sda_h1_q;
      sda_f_q  <= (sda_s2_q & sda_h1_q) | (sda_s2_q & sda_h2_q) | (sda_h1_q & sda_h2_q);
    end
  end

  assign scl_v = scl_f_q;
  assign sda_v = sda_f_q;
`else
  assign scl_v = scl_s2_q;
  assign sda_v = sda_s2_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_v;
      sda_prev_q <= sda_v;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_v & ~scl_prev_q;
  assign scl_fall  = ~scl_v & scl_prev_q;
  assign start_det = ~sda_v & sda_prev_q & scl_v & scl_prev_q;
  assign stop_det  = sda_v & ~sda_prev_q & scl_v & scl_prev_q;

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic        push, pop;
  logic [7:0]  rx_byte, head;

  assign head       = mem_q[rptr_q[AW-1:0]];
  assign fifo_count = wptr_q - rptr_q;
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= rx_byte;
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
  end

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_drv_q, sda_drv_d;
  logic       sda_oe_q;
  logic       phase_q, phase_d;
  logic       rw_q, rw_d;
  logic       ack_q, ack_d;
  logic       rd_fifo_q, rd_fifo_d;
  logic       busy_q, busy_d;
  logic       overflow_q, overflow_d;

  assign rx_byte  = {shift_q[6:0], sda_v};
  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sda_drv_d  = sda_drv_q;
    phase_d    = phase_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    rd_fifo_d  = rd_fifo_q;
    busy_d     = busy_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    pop        = 1'b0;

    if (stop_det) begin
      state_d   = IDLE;
      sda_drv_d = 1'b0;
      busy_d    = 1'b0;
      phase_d   = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_drv_d = 1'b0;
      busy_d    = 1'b0;
      phase_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            if (rx_byte[7:1] != SLAVE_ADDR) begin
              state_d = WAIT_STOP;
            end else begin
              busy_d  = 1'b1;
              rw_d    = rx_byte[0];
              state_d = (rx_byte[0] && fifo_empty) ? WAIT_STOP : ADDR_ACK;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_drv_d = 1'b1;
            phase_d   = 1'b1;
          end else begin
            phase_d   = 1'b0;
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              state_d   = RD_DATA;
              shift_d   = head;
              rd_fifo_d = 1'b1;
              sda_drv_d = ~head[7];
            end else begin
              state_d   = WR_DATA;
              sda_drv_d = 1'b0;
            end
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            state_d = WR_ACK;
            if (!fifo_full) begin
              push  = 1'b1;
              ack_d = 1'b1;
            end else begin
              ack_d      = 1'b0;
              overflow_d = 1'b1;
            end
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_drv_d = ack_q;
            phase_d   = 1'b1;
          end else begin
            sda_drv_d = 1'b0;
            phase_d   = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_drv_d = 1'b0;
              phase_d   = 1'b0;
              state_d   = RD_MACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b1};
              sda_drv_d = ~shift_q[6];
            end
          end
        end
        RD_MACK: begin
          if (scl_rise) begin
            pop = rd_fifo_q & ~fifo_empty;
            if (sda_v) state_d = WAIT_STOP;
            else       phase_d = 1'b1;
          end else if (scl_fall && phase_q) begin
            // An exhausted FIFO reads back as all-ones with SDA left released.
            phase_d   = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = RD_DATA;
            if (fifo_empty) begin
              shift_d   = 8'hFF;
              rd_fifo_d = 1'b0;
              sda_drv_d = 1'b0;
            end else begin
              shift_d   = head;
              rd_fifo_d = 1'b1;
              sda_drv_d = ~head[7];
            end
          end
        end
        IDLE, WAIT_STOP: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      sda_drv_q  <= 1'b0;
      sda_oe_q   <= 1'b0;
      phase_q    <= 1'b0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      rd_fifo_q  <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      sda_drv_q  <= sda_drv_d;
      sda_oe_q   <= sda_drv_q;
      phase_q    <= phase_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      rd_fifo_q  <= rd_fifo_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

endmodule

// File: tb/tb_i2c_fifo_slave.sv
// Directed bench for i2c_fifo_slave: a bit-banged master queues expected
// ACKs/bytes/status and a monitor pops and compares the observed values.
module tb_i2c_fifo_slave;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst, scl, sda_m;
  logic       sda_line, sda_oe;
  logic [3:0] fifo_count;
  logic       fifo_full, fifo_empty, overflow, busy;

  int checks = 0;
  int errors = 0;
  int oe_cycles = 0;

  string       exp_name_q[$];
  logic [31:0] exp_val_q[$];
  logic [31:0] obs_q[$];

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  always @(negedge clk) if (sda_oe) oe_cycles <= oe_cycles + 1;

  i2c_fifo_slave #(.DEPTH(8), .SLAVE_ADDR(7'h19)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .overflow(overflow), .busy(busy)
  );

  initial begin : monitor
    logic [31:0] o, e;
    string n;
    forever begin
      @(negedge clk);
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        checks++;
        if (exp_val_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output actual=%0h required=none", o);
        end else begin
          n = exp_name_q.pop_front();
          e = exp_val_q.pop_front();
          if (o !== e) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, o, e);
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_val(input string name, input logic [31:0] v);
    exp_name_q.push_back(name);
    exp_val_q.push_back(v);
  endtask

  task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] exp);
    expect_val(name, exp);
    obs_q.push_back(act);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    scl   = 1'b1;
    wait_clk(Q);
    sda_m = 1'b0;
    wait_clk(2*Q);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(Q);
    sda_m = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(2*Q);
    sda_m = 1'b1;
    wait_clk(2*Q);
  endtask

  task automatic bit_slot(input logic b, output logic s);
    wait_clk(Q);
    sda_m = b;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    s = sda_line;
    wait_clk(Q);
    scl = 1'b0;
  endtask

  // exp_line is the SDA level expected in the ACK slot: 0 = ACK, 1 = NACK
  task automatic send_byte(input logic [7:0] b, input logic exp_line, input string name);
    logic s;
    expect_val(name, {31'd0, exp_line});
    for (int i = 7; i >= 0; i--) bit_slot(b[i], s);
    bit_slot(1'b1, s);
    obs_q.push_back({31'd0, s});
  endtask

  task automatic read_byte(input logic [7:0] exp_b, input logic mack, input string name);
    logic s;
    logic [7:0] d;
    d = 8'h00;
    expect_val(name, {24'd0, exp_b});
    for (int i = 7; i >= 0; i--) begin
      bit_slot(1'b1, s);
      d[i] = s;
    end
    bit_slot(mack, s);
    obs_q.push_back({24'd0, d});
  endtask

  initial begin
    int oe_base;
    rst = 1'b1;
    scl = 1'b1;
    sda_m = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(2);
    check_now("rst_sda_oe", {31'd0, sda_oe}, 0);
    check_now("rst_busy", {31'd0, busy}, 0);
    check_now("rst_overflow", {31'd0, overflow}, 0);
    check_now("rst_count", {28'd0, fifo_count}, 0);
    check_now("rst_full", {31'd0, fifo_full}, 0);
    check_now("rst_empty", {31'd0, fifo_empty}, 1);

    bus_start();
    send_byte(8'h32, 1'b0, "w1_addr_ack");
    check_now("w1_busy_mid", {31'd0, busy}, 1);
    send_byte(8'h2F, 1'b0, "w1_data_ack");
    bus_stop();
    check_now("w1_count", {28'd0, fifo_count}, 1);
    check_now("w1_busy_after_stop", {31'd0, busy}, 0);

    bus_start();
    send_byte(8'h32, 1'b0, "w2_addr_ack");
    send_byte(8'hAE, 1'b0, "w2_data_ack");
    bus_stop();
    check_now("w2_count", {28'd0, fifo_count}, 2);

    bus_start();
    send_byte(8'h33, 1'b0, "r1_addr_ack");
    read_byte(8'h2F, 1'b0, "r1_byte1");
    read_byte(8'hAE, 1'b1, "r1_byte2");
    bus_stop();
    check_now("r1_empty", {31'd0, fifo_empty}, 1);
    check_now("r1_count", {28'd0, fifo_count}, 0);

    oe_base = oe_cycles;
    bus_start();
    send_byte(8'h34, 1'b1, "bad_addr_nack");
    send_byte(8'h55, 1'b1, "bad_addr_data_nack");
    bus_stop();
    check_now("bad_addr_oe_cycles", oe_cycles - oe_base, 0);
    check_now("bad_addr_count", {28'd0, fifo_count}, 0);

    bus_start();
    send_byte(8'h32, 1'b0, "ovf_addr_ack");
    for (int i = 1; i <= 9; i++) send_byte(i[7:0], (i == 9), "ovf_data_ack");
    bus_stop();
    check_now("ovf_overflow", {31'd0, overflow}, 1);
    check_now("ovf_count", {28'd0, fifo_count}, 8);
    check_now("ovf_full", {31'd0, fifo_full}, 1);

    bus_start();
    send_byte(8'h33, 1'b0, "drain_addr_ack");
    for (int i = 1; i <= 8; i++) read_byte(i[7:0], 1'b0, "drain_byte");
    read_byte(8'hFF, 1'b1, "drain_empty_ff");
    bus_stop();
    check_now("drain_count", {28'd0, fifo_count}, 0);
    check_now("drain_empty", {31'd0, fifo_empty}, 1);
    check_now("drain_full", {31'd0, fifo_full}, 0);

    bus_start();
    send_byte(8'h33, 1'b1, "rd_empty_addr_nack");
    bus_stop();
    check_now("rd_empty_busy", {31'd0, busy}, 0);

    bus_start();
    send_byte(8'h32, 1'b0, "w3_addr_ack");
    send_byte(8'h5A, 1'b0, "w3_data_ack");
    bus_stop();
    check_now("w3_count", {28'd0, fifo_count}, 1);

    bus_start();
    send_byte(8'h33, 1'b0, "rst_rd_addr_ack");
    wait_clk(Q);
    check_now("rst_rd_bit7_driven", {31'd0, sda_oe}, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_now("rst_rd_sda_oe", {31'd0, sda_oe}, 0);
    check_now("rst_rd_empty", {31'd0, fifo_empty}, 1);
    @(negedge clk);
    rst = 1'b0;
    sda_m = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(2*Q);
    check_now("rst_rd_overflow", {31'd0, overflow}, 0);
    check_now("rst_rd_count", {28'd0, fifo_count}, 0);

    wait_clk(5);
    checks++;
    if (exp_val_q.size() != 0 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d/%0d required=0/0", exp_val_q.size(), obs_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
